// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - state encoding and display helpers shared by the quiz buzzer blocks
package quiz_pkg;

  localparam int STATE_W      = 3;
  localparam int PLAYER_SCALE = 100;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ANSWER  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_FOUL    = 3'd4
  } state_t;

  // Tube value: player number in the hundreds digit, seconds in the low two digits.
  function automatic logic [9:0] disp_of(input logic [3:0] player, input logic [6:0] secs);
    return 10'(player) * 10'(PLAYER_SCALE) + 10'(secs);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-cycle tick every TICK_DIV clocks, realigned by restart
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // restart zeroes the count on the entry edge, so the first tick lands TICK_DIV cycles later
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/quiz_buzzer_ctrl.sv
// rtl/quiz_buzzer_ctrl.sv - quiz buzzer arbitration, host flow, foul detection and countdown
module quiz_buzzer_ctrl
  import quiz_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int TICK_DIV  = 50_000_000,
  parameter int ARM_SECS  = 10,
  parameter int ANS_SECS  = 20
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 host_start,
  input  logic                 host_clear,
  input  logic [N_PLAYERS-1:0] player_btn,
  output logic [9:0]           disp_value,
  output logic                 error_flag,
  output logic [3:0]           winner,
  output logic                 buzzer,
  output logic [2:0]           state_dbg
);

  localparam int NB = N_PLAYERS + 2;
  localparam logic [6:0] ARM_S = 7'(ARM_SECS);
  localparam logic [6:0] ANS_S = 7'(ANS_SECS);

  logic [NB-1:0] raw, sync1, sync2, prev, rise;
  logic [N_PLAYERS-1:0] press_vec;
  logic clear_evt, start_evt, press_any, tick, restart, timeout_evt;
  logic [3:0] press_id;
  logic [6:0] sec_left;
  state_t state;

  assign raw = {host_clear, host_start, player_btn};

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise      = sync2 & ~prev;
  assign clear_evt = rise[NB-1];
  assign start_evt = rise[NB-2];
  assign press_vec = rise[N_PLAYERS-1:0];
  assign press_any = |press_vec;

  // Descending scan so the lowest-indexed simultaneous press is the one kept.
  always_comb begin
    press_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press_vec[i]) press_id = 4'(i + 1);
    end
  end

  assign timeout_evt = tick && (sec_left <= 7'd1);

  // Mirrors every FSM transition so the tick phase starts fresh in each new state.
  always_comb begin
    restart = 1'b0;
    if (clear_evt) begin
      restart = 1'b1;
    end else begin
      case (state)
        ST_IDLE:   restart = start_evt | press_any;
        ST_ARMED:  restart = press_any | timeout_evt;
        ST_ANSWER: restart = timeout_evt;
        default:   restart = 1'b0;
      endcase
    end
  end

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sec_left   <= '0;
      winner     <= '0;
      disp_value <= '0;
      error_flag <= 1'b0;
      buzzer     <= 1'b0;
    end else if (clear_evt) begin
      state      <= ST_IDLE;
      sec_left   <= '0;
      winner     <= '0;
      disp_value <= '0;
      error_flag <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_any) begin
            state      <= ST_FOUL;
            winner     <= press_id;
            error_flag <= 1'b1;
            buzzer     <= 1'b1;
            disp_value <= disp_of(press_id, 7'd0);
          end else if (start_evt) begin
            state      <= ST_ARMED;
            sec_left   <= ARM_S;
            disp_value <= disp_of(4'd0, ARM_S);
          end
        end
        ST_ARMED: begin
          if (press_any) begin
            state      <= ST_ANSWER;
            winner     <= press_id;
            sec_left   <= ANS_S;
            disp_value <= disp_of(press_id, ANS_S);
          end else if (timeout_evt) begin
            state      <= ST_TIMEOUT;
            sec_left   <= '0;
            winner     <= '0;
            buzzer     <= 1'b1;
            disp_value <= '0;
          end else if (tick) begin
            sec_left   <= sec_left - 7'd1;
            disp_value <= disp_of(4'd0, sec_left - 7'd1);
          end
        end
        ST_ANSWER: begin
          if (timeout_evt) begin
            state      <= ST_TIMEOUT;
            sec_left   <= '0;
            buzzer     <= 1'b1;
            disp_value <= disp_of(winner, 7'd0);
          end else if (tick) begin
            sec_left   <= sec_left - 7'd1;
            disp_value <= disp_of(winner, sec_left - 7'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_quiz_buzzer_ctrl.sv
// tb/tb_quiz_buzzer_ctrl.sv - directed vector bench for quiz_buzzer_ctrl
module tb_quiz_buzzer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_start, host_clear;
  logic [3:0] player_btn;
  logic [9:0] disp_value;
  logic       error_flag;
  logic [3:0] winner;
  logic       buzzer;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quiz_buzzer_ctrl #(
    .N_PLAYERS(4), .TICK_DIV(10), .ARM_SECS(3), .ANS_SECS(5)
  ) dut (
    .clk_50M    (clk),
    .rst_n      (rst_n),
    .host_start (host_start),
    .host_clear (host_clear),
    .player_btn (player_btn),
    .disp_value (disp_value),
    .error_flag (error_flag),
    .winner     (winner),
    .buzzer     (buzzer),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic       start;
    logic       clear;
    logic [3:0] btn;
    int         cyc;
    logic [9:0] disp;
    logic       err;
    logic [3:0] win;
    logic       buzz;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic run(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] ed, input logic ee,
                       input logic [3:0] ew, input logic eb, input logic [2:0] es);
    checks++;
    if ({disp_value, error_flag, winner, buzzer, state_dbg} !== {ed, ee, ew, eb, es}) begin
      errors++;
      $display("FAIL %s: got disp=%0d err=%0b win=%0d buzz=%0b st=%0d, want disp=%0d err=%0b win=%0d buzz=%0b st=%0d",
               name, disp_value, error_flag, winner, buzzer, state_dbg, ed, ee, ew, eb, es);
    end
  endtask

  initial begin
    // start clear btn cyc | disp err win buzz st
    tbl.push_back('{0,0,4'b0000, 5,   0,0,0,0,0});
    tbl.push_back('{1,0,4'b0000, 3,   3,0,0,0,1});
    tbl.push_back('{0,0,4'b0000,10,   2,0,0,0,1});
    tbl.push_back('{0,0,4'b0000,10,   1,0,0,0,1});
    tbl.push_back('{0,0,4'b0100, 3, 305,0,3,0,2});
    tbl.push_back('{0,0,4'b0000, 9, 305,0,3,0,2});
    tbl.push_back('{0,0,4'b0000, 1, 304,0,3,0,2});
    tbl.push_back('{0,0,4'b0000,30, 301,0,3,0,2});
    tbl.push_back('{0,0,4'b0000, 9, 301,0,3,0,2});
    tbl.push_back('{0,0,4'b0000, 1, 300,0,3,1,3});
    tbl.push_back('{0,1,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{0,0,4'b0010, 3, 200,1,2,1,4});
    tbl.push_back('{0,0,4'b0000, 5, 200,1,2,1,4});
    tbl.push_back('{0,1,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{1,0,4'b0000, 3,   3,0,0,0,1});
    tbl.push_back('{0,0,4'b1010, 3, 205,0,2,0,2});
    tbl.push_back('{0,0,4'b0000, 3, 205,0,2,0,2});
    tbl.push_back('{0,0,4'b0001, 3, 205,0,2,0,2});
    tbl.push_back('{0,0,4'b0000, 4, 204,0,2,0,2});
    tbl.push_back('{1,0,4'b0000, 3, 204,0,2,0,2});
    tbl.push_back('{0,1,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{1,0,4'b0000, 3,   3,0,0,0,1});
    tbl.push_back('{0,0,4'b0000,10,   2,0,0,0,1});
    tbl.push_back('{0,0,4'b0000,10,   1,0,0,0,1});
    tbl.push_back('{0,0,4'b0000, 9,   1,0,0,0,1});
    tbl.push_back('{0,0,4'b0000, 1,   0,0,0,1,3});
    tbl.push_back('{0,1,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{0,0,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{1,1,4'b0000, 3,   0,0,0,0,0});
    tbl.push_back('{0,0,4'b0000, 3,   0,0,0,0,0});

    rst_n = 1'b0;
    host_start = 1'b0;
    host_clear = 1'b0;
    player_btn = 4'b0000;
    run(3);
    check("reset_held", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    run(1);
    check("reset_released", 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      host_start = tbl[i].start;
      host_clear = tbl[i].clear;
      player_btn = tbl[i].btn;
      run(tbl[i].cyc);
      check($sformatf("vec%0d", i), tbl[i].disp, tbl[i].err, tbl[i].win, tbl[i].buzz, tbl[i].st);
    end

    // Reset pulsed in the middle of an answer countdown.
    host_start = 1'b1;
    run(3);
    check("rst_seq_armed", 3, 0, 0, 0, 1);
    host_start = 1'b0;
    player_btn = 4'b1000;
    run(3);
    check("rst_seq_win4", 405, 0, 4, 0, 2);
    player_btn = 4'b0000;
    run(20);
    check("rst_seq_403", 403, 0, 4, 0, 2);
    rst_n = 1'b0;
    #2;
    check("rst_async_clear", 0, 0, 0, 0, 0);
    run(2);
    check("rst_held_mid", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    run(2);
    host_start = 1'b1;
    run(3);
    check("post_rst_armed", 3, 0, 0, 0, 1);
    host_start = 1'b0;
    player_btn = 4'b0100;
    run(3);
    check("post_rst_win3", 305, 0, 3, 0, 2);
    player_btn = 4'b0000;
    run(10);
    check("post_rst_304", 304, 0, 3, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
